// File: rtl/peri_pkg.sv
// Shared address map and address type for the input peripheral slice.
package peri_pkg;

    typedef logic [7:0] peri_addr_t;

    localparam peri_addr_t ADDR_SW       = 8'h00;
    localparam peri_addr_t ADDR_BTN      = 8'h10;
    localparam peri_addr_t ADDR_EDGE     = 8'h14;
    localparam peri_addr_t ADDR_IRQ_MASK = 8'h18;

    // Registers are word aligned, so the byte offset never takes part in decode.
    function automatic peri_addr_t word_addr(input peri_addr_t a);
        return {a[7:2], 2'b00};
    endfunction

endpackage

// File: rtl/input_peri_if.sv
// LSU peripheral bus as seen by the input peripheral: core drives address/write, peripheral returns read data and irq.
interface input_peri_if;
    import peri_pkg::*;

    peri_addr_t  addr;
    logic [31:0] w_data;
    logic        wr_en;
    logic [3:0]  bmask;
    logic [31:0] rd_data;
    logic        irq;

    modport master (
        output addr, w_data, wr_en, bmask,
        input  rd_data, irq
    );

    modport slave (
        input  addr, w_data, wr_en, bmask,
        output rd_data, irq
    );

endinterface

// File: rtl/input_peri_btn_debounce.sv
// One push button: 2-flop synchroniser on the active-low pad followed by a stable-count debouncer.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_n,
    output logic state,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          pressed_s;
    logic          accept;

    assign pressed_s = ~sync2;
    assign accept    = (pressed_s != state) && (cnt == CNT_LAST);
    assign press     = accept && pressed_s;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pad_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (accept) begin
            state <= pressed_s;
            cnt   <= '0;
        end else if (pressed_s != state) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/input_peri.sv
// Memory-mapped switch/button input peripheral with W1C press-edge register.
// Optional interrupt mask and registered irq are enabled by defining INPUT_PERI_IRQ_EN.
module input_peri
    import peri_pkg::*;
#(
    parameter int SW_WIDTH        = 18,
    parameter int BTN_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input_peri_if.slave          bus,
    input  logic [SW_WIDTH-1:0]  io_sw,
    input  logic [BTN_WIDTH-1:0] io_btn_n
);

    logic [SW_WIDTH-1:0]  sw_sync1;
    logic [SW_WIDTH-1:0]  sw_sync2;
    logic [BTN_WIDTH-1:0] btn_state;
    logic [BTN_WIDTH-1:0] btn_press;
    logic [BTN_WIDTH-1:0] edge_q;
    logic [BTN_WIDTH-1:0] edge_clr;
    peri_addr_t           waddr;
    logic                 wr_low_byte;
    logic                 unused_bits;

    assign waddr       = word_addr(bus.addr);
    assign wr_low_byte = bus.wr_en && bus.bmask[0];
    assign edge_clr    = (wr_low_byte && waddr == ADDR_EDGE) ? bus.w_data[BTN_WIDTH-1:0] : '0;
    assign unused_bits = ^{bus.addr[1:0], bus.w_data, bus.bmask};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= io_sw;
            sw_sync2 <= sw_sync1;
        end
    end

    for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .pad_n (io_btn_n[i]),
            .state (btn_state[i]),
            .press (btn_press[i])
        );
    end

    // A new press on the same edge as a clear must survive, so set is ORed in last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q <= '0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | btn_press;
        end
    end

`ifdef INPUT_PERI_IRQ_EN
    logic [BTN_WIDTH-1:0] irq_mask_q;
    logic                 irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_low_byte && waddr == ADDR_IRQ_MASK) begin
                irq_mask_q <= bus.w_data[BTN_WIDTH-1:0];
            end
            irq_q <= |(edge_q & irq_mask_q);
        end
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        bus.rd_data = '0;
        case (waddr)
            ADDR_SW:       bus.rd_data[SW_WIDTH-1:0]  = sw_sync2;
            ADDR_BTN:      bus.rd_data[BTN_WIDTH-1:0] = btn_state;
            ADDR_EDGE:     bus.rd_data[BTN_WIDTH-1:0] = edge_q;
`ifdef INPUT_PERI_IRQ_EN
            ADDR_IRQ_MASK: bus.rd_data[BTN_WIDTH-1:0] = irq_mask_q;
`endif
            default:       bus.rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_input_peri.sv
// Scoreboard bench for input_peri with DEBOUNCE_CYCLES=4; checks IRQ_MASK/irq when INPUT_PERI_IRQ_EN is defined.
module tb_input_peri;

    typedef struct {
        string       name;
        bit          is_irq;
        logic [31:0] value;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [17:0] io_sw;
    logic [3:0]  io_btn_n;
    exp_t        exp_q[$];
    event        push_ev;
    int          n_checks;
    int          n_fail;

    input_peri_if bus();

    input_peri #(
        .SW_WIDTH        (18),
        .BTN_WIDTH       (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .io_sw    (io_sw),
        .io_btn_n (io_btn_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: whenever an expectation is queued, sample the DUT output it names and compare.
    initial begin
        exp_t        e;
        logic [31:0] actual;
        forever begin
            @(push_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                actual = e.is_irq ? {31'b0, bus.irq} : bus.rd_data;
                n_checks++;
                if (actual !== e.value) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, actual, e.value);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.addr   = a;
        bus.w_data = d;
        bus.bmask  = m;
        bus.wr_en  = 1'b1;
        tick(1);
        bus.wr_en  = 1'b0;
        bus.bmask  = 4'b0000;
    endtask

    task automatic checkOutput(input string name, input bit is_irq, input logic [7:0] a,
                               input logic [31:0] v);
        exp_t e;
        e.name   = name;
        e.is_irq = is_irq;
        e.value  = v;
        if (!is_irq) bus.addr = a;
        exp_q.push_back(e);
        -> push_ev;
        for (int t = 0; t < 5 && exp_q.size() != 0; t++) #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: got no sample expected monitor to consume entry", name);
            exp_q.delete();
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        io_sw       = '0;
        io_btn_n    = 4'b1111;
        bus.addr    = 8'h00;
        bus.w_data  = '0;
        bus.wr_en   = 1'b0;
        bus.bmask   = 4'b0000;

        tick(3);
        checkOutput("reset_sw", 0, 8'h00, 32'h0);
        checkOutput("reset_btn", 0, 8'h10, 32'h0);
        checkOutput("reset_irq", 1, 8'h00, 32'h0);
        rst = 1'b0;
        tick(1);
        checkOutput("post_reset_edge", 0, 8'h14, 32'h0);
        checkOutput("post_reset_btn", 0, 8'h10, 32'h0);

        // Switch synchroniser latency: two edges.
        io_sw = 18'h2A5A5;
        tick(1);
        checkOutput("sw_edge1", 0, 8'h00, 32'h0);
        tick(1);
        checkOutput("sw_edge2", 0, 8'h00, 32'h0002A5A5);

        // Stable press of button 0 is accepted DEBOUNCE_CYCLES+2 = 6 edges later.
        io_btn_n = 4'b1110;
        tick(5);
        checkOutput("btn0_edge5_btn", 0, 8'h10, 32'h0);
        checkOutput("btn0_edge5_edge", 0, 8'h14, 32'h0);
        tick(1);
        checkOutput("btn0_edge6_btn", 0, 8'h10, 32'h1);
        checkOutput("btn0_edge6_edge", 0, 8'h14, 32'h1);
        checkOutput("btn0_irq_direct", 1, 8'h00, 32'h0);

        // Three-cycle glitch on button 1 must be rejected.
        io_btn_n = 4'b1100;
        tick(3);
        io_btn_n = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            tick(5);
            checkOutput("glitch_btn", 0, 8'h10, 32'h1);
            checkOutput("glitch_edge", 0, 8'h14, 32'h1);
        end

        io_btn_n = 4'b1100;
        tick(6);
        checkOutput("btn1_press_btn", 0, 8'h10, 32'h3);
        checkOutput("btn1_press_edge", 0, 8'h14, 32'h3);

        applyStimulus(8'h14, 32'h1, 4'b0001);
        checkOutput("w1c_bit0", 0, 8'h14, 32'h2);
        checkOutput("w1c_btn_untouched", 0, 8'h10, 32'h3);
        applyStimulus(8'h14, 32'h3, 4'b0000);
        checkOutput("w1c_no_bmask", 0, 8'h14, 32'h2);
        applyStimulus(8'h10, 32'h0, 4'b1111);
        checkOutput("ro_write_btn", 0, 8'h10, 32'h3);
        applyStimulus(8'h20, 32'hFFFF_FFFF, 4'b1111);
        checkOutput("unmapped_read", 0, 8'h20, 32'h0);
        checkOutput("byte_offset_edge", 0, 8'h17, 32'h2);

        // Clear bit 0 on the very edge a new press re-sets it.
        io_btn_n = 4'b1101;
        tick(6);
        checkOutput("btn0_release_btn", 0, 8'h10, 32'h2);
        checkOutput("release_no_edge", 0, 8'h14, 32'h2);
        io_btn_n = 4'b1100;
        tick(5);
        applyStimulus(8'h14, 32'h1, 4'b0001);
        checkOutput("set_wins_edge", 0, 8'h14, 32'h3);
        checkOutput("set_wins_btn", 0, 8'h10, 32'h3);
        applyStimulus(8'h14, 32'hF, 4'b0001);
        checkOutput("clear_all_edge", 0, 8'h14, 32'h0);

`ifdef INPUT_PERI_IRQ_EN
        applyStimulus(8'h18, 32'hFF, 4'b0001);
        checkOutput("mask_width", 0, 8'h18, 32'hF);
        applyStimulus(8'h18, 32'h1, 4'b0001);
        checkOutput("mask_bit0", 0, 8'h18, 32'h1);
        io_btn_n = 4'b1101;
        tick(6);
        checkOutput("irq_prep_btn", 0, 8'h10, 32'h2);
        io_btn_n = 4'b1100;
        tick(6);
        checkOutput("irq_edge_set", 0, 8'h14, 32'h1);
        checkOutput("irq_not_yet", 1, 8'h00, 32'h0);
        tick(1);
        checkOutput("irq_rise", 1, 8'h00, 32'h1);
        applyStimulus(8'h14, 32'h1, 4'b0001);
        checkOutput("irq_w1c_edge", 0, 8'h14, 32'h0);
        checkOutput("irq_still_high", 1, 8'h00, 32'h1);
        tick(1);
        checkOutput("irq_fall", 1, 8'h00, 32'h0);
`else
        applyStimulus(8'h18, 32'h1, 4'b0001);
        checkOutput("mask_absent", 0, 8'h18, 32'h0);
        checkOutput("irq_absent", 1, 8'h00, 32'h0);
`endif

        // Asynchronous reset in the middle of a release debounce (cnt=2).
        io_btn_n = 4'b1000;
        tick(6);
        checkOutput("btn2_press_btn", 0, 8'h10, 32'h7);
        checkOutput("btn2_press_edge", 0, 8'h14, 32'h4);
        io_btn_n = 4'b1111;
        tick(4);
        checkOutput("mid_debounce_btn", 0, 8'h10, 32'h7);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_btn", 0, 8'h10, 32'h0);
        checkOutput("async_rst_edge", 0, 8'h14, 32'h0);
        checkOutput("async_rst_irq", 1, 8'h00, 32'h0);
        tick(1);
        checkOutput("async_rst_sw", 0, 8'h00, 32'h0);
        rst = 1'b0;
        tick(8);
        checkOutput("after_rst_btn", 0, 8'h10, 32'h0);
        checkOutput("after_rst_edge", 0, 8'h14, 32'h0);
        checkOutput("after_rst_sw", 0, 8'h00, 32'h0002A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_peri.md
Name: input_peri

Overview:
- Memory-mapped input peripheral; the read-side counterpart of the LED/HEX/LCD output peripheral on the same LSU peripheral bus.
- Synchronises the board slide switches and push buttons, and debounces the buttons.
- Latches button-press events in a write-1-to-clear edge register.
- Returns all of this to the single-cycle core through a combinational read port.

Parameters:
- SW_WIDTH, 18, number of slide switches (1..32).
- BTN_WIDTH, 4, number of push buttons (1..8).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a button change (>=2; 1 ms at 50 MHz).

Ports:
- clk  in  1  system clock; every flop updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- addr  in  8  byte address within the peripheral window.
- w_data  in  32  write data.
- wr_en  in  1  write strobe, sampled at posedge clk.
- bmask  in  4  byte enables for the write.
- rd_data  out  32  read data, combinational from addr.
- io_sw  in  SW_WIDTH  raw switch pads, asynchronous; 1 = on.
- io_btn_n  in  BTN_WIDTH  raw button pads, asynchronous, active-low (0 = pressed).
- irq  out  1  interrupt request (present only with the optional feature; otherwise tied 0).

Behaviour:
- Reset (async, rst=1):
  - Switch sync flops are 0.
  - Button sync flops are 1 (released).
  - Debounced state is 0 (not pressed).
  - Debounce counters are 0.
  - EDGE is 0, IRQ_MASK is 0, irq is 0.
  - rd_data follows the cleared registers.
- Synchronisers: every switch and button pad passes through a 2-flop synchroniser. The switch value is readable 2 edges after a pad change.
- Button debounce, per bit:
  - pressed_s = ~synced pad.
  - If pressed_s != state: cnt increments.
  - If pressed_s == state: cnt is cleared to 0.
  - When cnt == DEBOUNCE_CYCLES-1 and pressed_s != state: at that edge, state <= pressed_s and cnt <= 0.
  - A stable pad change therefore reaches state DEBOUNCE_CYCLES+2 edges later.
  - A glitch shorter than DEBOUNCE_CYCLES cycles causes no state change.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it never wraps.
- EDGE register:
  - Bit i sets on the same edge that state[i] goes 0 -> 1. Releases do not set it.
  - A write to 0x14 with bmask[0]=1 clears every bit where w_data[i]=1.
  - If a set and a clear happen on the same edge, the set wins.
- Register map (word aligned; addr[1:0] ignored):
  - 0x00 SW: RO. {zeros, synced io_sw}.
  - 0x10 BTN: RO. {zeros, debounced state}.
  - 0x14 EDGE: RW1C. {zeros, edge bits}.
  - 0x18 IRQ_MASK: RW (feature only). Byte 0 is written when bmask[0]=1. Bits at or above BTN_WIDTH read 0.
- Unmapped addresses read 0 and ignore writes.
- Writes to RO registers are ignored.
- Read-after-write: a read of EDGE in the cycle after a clear returns the updated value.

Optional Feature:
- Macro: INPUT_PERI_IRQ_EN.
- Defined:
  - The IRQ_MASK register exists.
  - irq is registered: irq <= |(EDGE & IRQ_MASK), so it rises one edge after the enabling bit sets.
  - irq clears one edge after the W1C write or the mask write.
- Undefined:
  - No IRQ_MASK flops; 0x18 behaves as unmapped.
  - irq is constant 0.

Decomposition:
- Package peri_pkg holds:
  - Address constants ADDR_SW=8'h00, ADDR_BTN=8'h10, ADDR_EDGE=8'h14, ADDR_IRQ_MASK=8'h18.
  - A shared typedef for the 8-bit peripheral address.
- One sub-module, btn_debounce: synchroniser plus counter for one button, parameterised by DEBOUNCE_CYCLES. input_peri instantiates it BTN_WIDTH times via generate.
- Switch synchronisers and the register file stay inline in input_peri.

Test Plan (DEBOUNCE_CYCLES=4):
- Hold rst=1, then release; read 0x00, 0x10 and 0x14 -> all 32'h0; irq=0.
- Set io_sw=18'h2A5A5. After 1 edge, addr=0x00 reads 0. After the 2nd edge it reads 32'h0002A5A5.
- Drive io_btn_n[0]=0 stably. 0x10 reads 1 and 0x14 reads 1 exactly 6 edges later, not at edge 5.
- Drive io_btn_n[1] low for 3 cycles, then high. 0x10 and 0x14 stay 0 for 20 cycles.
- With EDGE=4'b0011: write 0x14, w_data=32'h1, bmask=4'b0001 -> EDGE reads 4'b0010. Repeat with bmask=4'b0000 -> no change. Clear on the same edge that bit 0 re-sets -> bit 0 stays 1.
- INPUT_PERI_IRQ_EN defined: write 0x18=32'h1, then press button 0. irq rises 1 edge after EDGE[0] sets and falls 1 edge after a W1C of bit 0. Assert rst mid-debounce (cnt=2) -> counters, EDGE and irq are 0 immediately.
